// File: rtl/bcd_to_bin_seq.sv
// Sequential signed BCD-to-binary converter using reverse double-dabble, one bit per cycle.
// Define BCD_TO_BIN_SAT_EN to saturate bin_out on overflow instead of wrapping.
module bcd_to_bin_seq #(
    parameter int BITS   = 16,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_sign,
    output logic                  busy,
    output logic                  done,
    output logic [BITS-1:0]       bin_out,
    output logic                  over,
    output logic                  err
);

    localparam int NB = 4 * DIGITS;
    localparam int W  = (NB > BITS) ? NB : BITS;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] LAST      = CW'(NB - 1);
    localparam logic [W:0]    ONE_W     = {{W{1'b0}}, 1'b1};
    localparam logic [W:0]    NEG_LIMIT = ONE_W << (BITS - 1);
    localparam logic [W:0]    POS_LIMIT = NEG_LIMIT - ONE_W;

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, FINISH} state_t;

    state_t          state, state_next;
    logic [NB-1:0]   bcd_reg, acc;
    logic [NB-1:0]   bcd_shifted, bcd_fixed, acc_shifted;
    logic [CW-1:0]   count;
    logic            sign_reg;
    logic            err_flag;
    logic            bad_digit;
    logic [W:0]      mag;
    logic [BITS-1:0] mag_neg;
    logic            res_over;
    logic [BITS-1:0] res_bin;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_reg[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then pull each nibble back into BCD range.
    always_comb begin
        {bcd_shifted, acc_shifted} = {bcd_reg, acc} >> 1;
        bcd_fixed = bcd_shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shifted[4*i +: 4] >= 4'd8) begin
                bcd_fixed[4*i +: 4] = bcd_shifted[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        mag      = (W+1)'(acc);
        mag_neg  = ~mag[BITS-1:0] + ONE_W[BITS-1:0];
        res_over = sign_reg ? (mag > NEG_LIMIT) : (mag > POS_LIMIT);
        res_bin  = sign_reg ? mag_neg : mag[BITS-1:0];
`ifdef BCD_TO_BIN_SAT_EN
        if (res_over) begin
            res_bin = sign_reg ? NEG_LIMIT[BITS-1:0] : POS_LIMIT[BITS-1:0];
        end
`else
        res_bin = res_bin;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = bad_digit ? FINISH : SHIFT;
            SHIFT:   if (count == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy stays set through FINISH so it overlaps the done cycle, then follows start in IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            bin_out  <= '0;
            over     <= 1'b0;
            err      <= 1'b0;
            acc      <= '0;
            bcd_reg  <= '0;
            count    <= '0;
            sign_reg <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        bcd_reg  <= bcd_in;
                        sign_reg <= in_sign;
                        acc      <= '0;
                        err_flag <= 1'b0;
                    end
                end
                CHECK: begin
                    count    <= '0;
                    err_flag <= bad_digit;
                end
                SHIFT: begin
                    bcd_reg <= bcd_fixed;
                    acc     <= acc_shifted;
                    count   <= count + CW'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    err  <= err_flag;
                    if (err_flag) begin
                        bin_out <= '0;
                        over    <= 1'b0;
                    end else begin
                        bin_out <= res_bin;
                        over    <= res_over;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 The block SHALL have parameter BITS, default 16, binary result width (2^n, n>1).
REQ-002 The block SHALL have parameter DIGITS, default 6, number of BCD digits on input.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port START, input, 1, a conversion request sampled in IDLE.
REQ-006 The block SHALL have port BCD_IN, input, 4*DIGITS, the magnitude with digit 0 in [3:0].
REQ-007 The block SHALL have port IN_SIGN, input, 1, where 1 means the value is negative.
REQ-008 The block SHALL have port BUSY, output, 1, high from the capture cycle until DONE inclusive.
REQ-009 The block SHALL have port DONE, output, 1, a one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port BIN_OUT, output, BITS, the two's-complement result, held until the next DONE.
REQ-011 The block SHALL have port OVER, output, 1, result out of signed BITS range, valid with DONE and held.
REQ-012 The block SHALL have port ERR, output, 1, any BCD digit > 9, valid with DONE and held.

Function
REQ-013 The FSM SHALL have states IDLE, CHECK, SHIFT and FINISH.
- IDLE -> CHECK when START=1: BCD_IN and IN_SIGN are captured; BUSY goes high.
REQ-014 In CHECK, if any captured nibble > 9, the FSM SHALL go to FINISH with an error flag set; otherwise it SHALL clear the counter and go to SHIFT.
REQ-015 SHIFT SHALL run exactly 4*DIGITS cycles (reverse double-dabble).
- Each cycle: shift {bcd_reg, acc} right by 1.
- Then subtract 3 from every bcd_reg nibble that is >= 8.
- acc is 4*DIGITS bits wide.
REQ-016 In FINISH, the block SHALL update BIN_OUT, OVER, ERR and DONE per REQ-017..019, then return to IDLE.
- BUSY and DONE are both high in that cycle.
REQ-017 Latency SHALL be START high in IDLE to DONE high = 4*DIGITS+2 cycles when valid, 2 cycles when ERR.
REQ-018 Range rules SHALL be as follows.
- Positive: OVER=1 if magnitude > 2^(BITS-1)-1.
- Negative: OVER=1 if magnitude > 2^(BITS-1).
- Negative results are the two's complement of the magnitude.
- Negative zero yields BIN_OUT=0 with OVER=0.
REQ-019 On ERR, the block SHALL set BIN_OUT=0 and OVER=0.
REQ-020 START SHALL be ignored in every state other than IDLE, including FINISH; no request is queued.
REQ-021 Changes to BCD_IN and IN_SIGN after the capture cycle SHALL have no effect on the conversion in progress.

Reset
REQ-022 With RESET_N=0 at a clock edge, the block SHALL go to IDLE and clear BUSY, DONE, OVER, ERR, BIN_OUT, acc, bcd_reg and the counter.
REQ-023 Reset mid-conversion SHALL abort it with no DONE pulse; the first START after release restarts normally.
REQ-024 Reset SHALL take priority over START in the same cycle.

Configuration
REQ-025 With macro BCD_TO_BIN_SAT_EN defined, BIN_OUT SHALL saturate on OVER: 2^(BITS-1)-1 for positive, -2^(BITS-1) for negative.
REQ-026 Without BCD_TO_BIN_SAT_EN, BIN_OUT SHALL be the low BITS bits of the signed result (wrap); OVER is flagged identically in both builds.

Verification (BITS=16, DIGITS=6)
REQ-027 BCD_IN=0x001234, IN_SIGN=0, START -> DONE at cycle 26, BIN_OUT=0x04D2, OVER=0, ERR=0.
REQ-028 BCD_IN=0x032767, IN_SIGN=1 -> BIN_OUT=0x8001, OVER=0; then 0x032768, IN_SIGN=1 -> BIN_OUT=0x8000, OVER=0.
REQ-029 BCD_IN=0x032768, IN_SIGN=0 -> OVER=1; BIN_OUT=0x7FFF with BCD_TO_BIN_SAT_EN, 0x8000 without.
REQ-030 BCD_IN=0x00A001 -> DONE at cycle 2, ERR=1, BIN_OUT=0x0000; next conversion of 0x000005 -> 0x0005, ERR=0.
REQ-031 START 0x999999 (IN_SIGN=0); pulse RESET_N low at cycle 10; START 0x000010 -> no DONE from the first; second gives BIN_OUT=0x000A (0x999999 alone: OVER=1).
REQ-032 START held high continuously with BCD_IN=0x000007 -> DONE every 27 cycles, BIN_OUT=0x0007; pulses during BUSY are ignored.
